// File: rtl/dmac_rr_arbiter.sv
// Round-robin arbiter merging per-channel valid/ready requests onto one port.
// Ports: clk, rst_n, src_valid_i/src_data_i/src_ready_o (per requester),
//   dst_valid_o/dst_data_o/dst_ready_i (merged), grant_o (one-hot grant),
//   src_last_i (only with DMAC_ARB_BURST_LOCK_EN: hold grant to last beat).
module dmac_rr_arbiter #(
  parameter int N_MASTER = 4,
  parameter int DATA_W   = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef DMAC_ARB_BURST_LOCK_EN
  input  logic [N_MASTER-1:0]        src_last_i,
`endif
  input  logic [N_MASTER-1:0]        src_valid_i,
  input  logic [N_MASTER*DATA_W-1:0] src_data_i,
  output logic [N_MASTER-1:0]        src_ready_o,
  output logic                       dst_valid_o,
  output logic [DATA_W-1:0]          dst_data_o,
  input  logic                       dst_ready_i,
  output logic [N_MASTER-1:0]        grant_o
);

  localparam int PTR_W = $clog2(N_MASTER);

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t             state_r;
  logic [PTR_W-1:0]   grant_r;
  logic [PTR_W-1:0]   rr_ptr_r;
  logic               en_r;

  logic [PTR_W-1:0]   sel;
  logic [PTR_W-1:0]   cur;
  logic               any_v;
  logic               route;
  logic               hs;
  int                 idx;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    if (int'(p) == N_MASTER - 1)
      return '0;
    return p + PTR_W'(1);
  endfunction

  // Scan from the pointer downwards in priority so the
  // requester closest to rr_ptr_r is written last and wins.
  always_comb begin
    any_v = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = N_MASTER - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_r) + i;
      if (idx >= N_MASTER)
        idx = idx - N_MASTER;
      if (src_valid_i[PTR_W'(idx)]) begin
        any_v = 1'b1;
        sel   = PTR_W'(idx);
      end
    end
  end

  assign cur   = (state_r == LOCK) ? grant_r : sel;
  assign route = en_r & ((state_r == LOCK) | any_v);

  always_comb begin
    grant_o     = '0;
    src_ready_o = '0;
    dst_valid_o = 1'b0;
    dst_data_o  = '0;
    if (route) begin
      grant_o[cur]     = 1'b1;
      src_ready_o[cur] = dst_ready_i;
      dst_valid_o      = src_valid_i[cur];
      dst_data_o       = src_data_i[int'(cur)*DATA_W +: DATA_W];
    end
  end

  assign hs = dst_valid_o & dst_ready_i;

`ifdef DMAC_ARB_BURST_LOCK_EN
  logic cur_last;
  assign cur_last = src_last_i[cur];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      grant_r  <= '0;
      rr_ptr_r <= '0;
      en_r     <= 1'b0;
    end else if (!en_r) begin
      en_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_v) begin
            if (!dst_ready_i) begin
              state_r <= LOCK;
              grant_r <= sel;
            end else begin
`ifdef DMAC_ARB_BURST_LOCK_EN
              if (cur_last) begin
                rr_ptr_r <= ptr_inc(sel);
              end else begin
                state_r <= LOCK;
                grant_r <= sel;
              end
`else
              rr_ptr_r <= ptr_inc(sel);
`endif
            end
          end
        end
        LOCK: begin
`ifdef DMAC_ARB_BURST_LOCK_EN
          if (hs && cur_last) begin
`else
          if (hs) begin
`endif
            state_r  <= IDLE;
            rr_ptr_r <= ptr_inc(grant_r);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_rr_arbiter.sv
// Scoreboard bench for dmac_rr_arbiter: directed scenarios plus
// random traffic checked against a queue-based reference model.
module tb_dmac_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    src_valid = '0;
  logic [N*DW-1:0] src_data = '0;
  logic [N-1:0]    src_ready;
  logic            dst_valid;
  logic [DW-1:0]   dst_data;
  logic            dst_ready = 1'b0;
  logic [N-1:0]    grant;
`ifdef DMAC_ARB_BURST_LOCK_EN
  logic [N-1:0]    src_last = '1;
`endif

  always #5 clk = ~clk;

  dmac_rr_arbiter #(
    .N_MASTER(N),
    .DATA_W  (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef DMAC_ARB_BURST_LOCK_EN
    .src_last_i (src_last),
`endif
    .src_valid_i(src_valid),
    .src_data_i (src_data),
    .src_ready_o(src_ready),
    .dst_valid_o(dst_valid),
    .dst_data_o (dst_data),
    .dst_ready_i(dst_ready),
    .grant_o    (grant)
  );

  typedef struct packed {
    logic          v;
    logic [N-1:0]  g;
    logic [N-1:0]  r;
    logic [DW-1:0] d;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: "enabled", "locked to owner", "next in line".
  bit m_en, m_lock;
  int m_owner, m_ptr;
  bit cur_route, cur_hs;
  int cur_owner;
  int last_hs;

  function automatic void model_reset();
    m_en = 0; m_lock = 0; m_owner = 0; m_ptr = 0;
  endfunction

  function automatic void predict();
    exp_t e;
    e = '0;
    cur_route = 0; cur_hs = 0; cur_owner = 0;
    if (m_en && rst_n) begin
      if (m_lock) begin
        cur_route = 1; cur_owner = m_owner;
      end else begin
        for (int k = 0; k < N; k++)
          if (!cur_route && src_valid[(m_ptr + k) % N]) begin
            cur_route = 1; cur_owner = (m_ptr + k) % N;
          end
      end
      if (cur_route) begin
        e.v = src_valid[cur_owner];
        e.g = N'(1) << cur_owner;
        e.r = dst_ready ? e.g : '0;
        e.d = src_data[cur_owner*DW +: DW];
        cur_hs = e.v && dst_ready;
      end
    end
    q.push_back(e);
  endfunction

  function automatic void model_update();
    if (!rst_n) model_reset();
    else if (!m_en) m_en = 1;
    else if (cur_route) begin
      if (cur_hs) begin
        m_lock = 0; m_ptr = (cur_owner + 1) % N;
      end else if (!m_lock) begin
        m_lock = 1; m_owner = cur_owner;
      end
    end
  endfunction

  task automatic step(input logic rst, input logic [N-1:0] v,
                      input logic rdy);
    rst_n = rst;
    src_valid = v;
    dst_ready = rdy;
    if (!rst) model_reset();
    predict();
    @(posedge clk);
    last_hs = cur_hs ? cur_owner : -1;
    model_update();
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (dst_valid !== e.v || grant !== e.g ||
            src_ready !== e.r || dst_data !== e.d) begin
          miscompares++;
          $display("FAIL arb_out vec %0d: got v=%b g=%b r=%b d=%h want v=%b g=%b r=%b d=%h",
                   vectors, dst_valid, grant, src_ready, dst_data,
                   e.v, e.g, e.r, e.d);
        end
      end
    end
  end

  bit            pend[N];
  logic [DW-1:0] pd[N];
  logic [N-1:0]  rv;

  initial begin : stim
    for (int k = 0; k < N; k++)
      src_data[k*DW +: DW] = 64'hC0DE_0000 + 64'(k);
    model_reset();
    last_hs = -1;
    @(posedge clk); #1;
    // reset, then release with everyone requesting
    step(0, 4'b0000, 0);
    step(0, 4'b1111, 1);
    step(0, 4'b1111, 1);
    step(1, 4'b1111, 1);
    repeat (8) step(1, 4'b1111, 1);
    step(1, 4'b0000, 1);
    // lock on requester 2, requester 0 may not preempt
    step(1, 4'b0100, 0);
    repeat (3) step(1, 4'b0101, 0);
    step(1, 4'b0101, 1);
    step(1, 4'b0001, 1);
    // pointer to 3, then wrap-around 3 -> 0
    step(1, 4'b0100, 1);
    step(1, 4'b1001, 1);
    step(1, 4'b1001, 1);
    // reset while locked on requester 1
    step(1, 4'b0010, 0);
    step(0, 4'b0010, 0);
    step(0, 4'b0010, 0);
    step(1, 4'b0010, 1);
    step(1, 4'b0010, 1);
    step(1, 4'b0000, 0);
    // random traffic; requesters hold valid until accepted
    for (int k = 0; k < N; k++) pend[k] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(2) == 0) begin
          pend[k] = 1;
          pd[k] = {$urandom, $urandom};
        end
        src_data[k*DW +: DW] = pd[k];
        rv[k] = pend[k];
      end
      if ($urandom_range(99) == 0) begin
        step(0, rv, 1'($urandom_range(1)));
        for (int k = 0; k < N; k++) pend[k] = 0;
      end else begin
        step(1, rv, $urandom_range(3) != 0);
        if (last_hs >= 0) pend[last_hs] = 0;
      end
    end
    @(negedge clk); #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
